// File: rtl/iqueue_mw_pkg.sv
// Shared LC-3b front-end types: the instruction-queue entry layout and default depth.
package lc3b_types;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] instr;
  } lc3b_iqueue_entry;

  localparam int IQ_DEPTH = 8;

endpackage

// File: rtl/iq_ram2w2r.sv
// DEPTH x ENTRY_W register array with two write ports and two combinational read ports.
module iq_ram2w2r #(
  parameter int DEPTH   = 8,
  parameter int ENTRY_W = 32
) (
  input  logic                     clk,
  input  logic                     we0,
  input  logic [$clog2(DEPTH)-1:0] wa0,
  input  logic [ENTRY_W-1:0]       wd0,
  input  logic                     we1,
  input  logic [$clog2(DEPTH)-1:0] wa1,
  input  logic [ENTRY_W-1:0]       wd1,
  input  logic [$clog2(DEPTH)-1:0] ra0,
  output logic [ENTRY_W-1:0]       rd0,
  input  logic [$clog2(DEPTH)-1:0] ra1,
  output logic [ENTRY_W-1:0]       rd1
);

  logic [ENTRY_W-1:0] mem [DEPTH];

  // Callers never drive both ports to the same slot in one cycle.
  always_ff @(posedge clk) begin
    if (we0) mem[wa0] <= wd0;
    if (we1) mem[wa1] <= wd1;
  end

  assign rd0 = mem[ra0];
  assign rd1 = mem[ra1];

endmodule

// File: rtl/iqueue_mw.sv
// Two-in / two-out instruction queue between decode and issue, with flush,
// occupancy reporting and sticky protocol-error flags.
module iqueue_mw
  import lc3b_types::*;
#(
  parameter int DEPTH     = IQ_DEPTH,
  parameter int ENTRY_W   = $bits(lc3b_iqueue_entry),
  parameter int AFULL_LVL = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic [1:0]                 push_cnt,
  input  logic [ENTRY_W-1:0]         push_data0,
  input  logic [ENTRY_W-1:0]         push_data1,
  input  logic [1:0]                 pop_cnt,
  output logic [ENTRY_W-1:0]         out_data0,
  output logic [ENTRY_W-1:0]         out_data1,
  output logic                       out_valid0,
  output logic                       out_valid1,
  output logic [$clog2(DEPTH):0]     count,
  output logic [$clog2(DEPTH):0]     free,
  output logic                       full,
  output logic                       almost_full,
  output logic                       ovf_err,
  output logic                       unf_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] head, tail;
  logic [CW-1:0] cnt_q;
  logic          ovf_q, unf_q;

  // Handshake: the producer offers push_cnt entries and all of them are taken
  // only when they fit in the start-of-cycle free space, otherwise none are;
  // issue may consume up to pop_cnt entries, clamped to what out_valid* show.
  logic [CW-1:0] free_w, pop_ext, push_ext, eff_pop, acc;
  logic          push_ok, push_bad, pop_bad;
  logic          we0, we1;

  always_comb begin
    free_w   = CW'(DEPTH) - cnt_q;
    pop_ext  = CW'(pop_cnt);
    push_ext = CW'(push_cnt);
    eff_pop  = (pop_ext > cnt_q) ? cnt_q : pop_ext;
    pop_bad  = (pop_cnt == 2'd3) || (pop_ext > cnt_q);
    push_bad = (push_cnt == 2'd3);
    push_ok  = !push_bad && (push_ext <= free_w);
    acc      = push_ok ? push_ext : '0;
    we0      = !flush && push_ok && (push_cnt != 2'd0);
    we1      = !flush && push_ok && (push_cnt == 2'd2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      cnt_q <= '0;
    end else begin
      head  <= head + PW'(eff_pop);
      tail  <= tail + PW'(acc);
      cnt_q <= cnt_q - eff_pop + acc;
      if (pop_bad || push_bad)             unf_q <= 1'b1;
      if (!push_bad && !push_ok)           ovf_q <= 1'b1;
    end
  end

  iq_ram2w2r #(.DEPTH(DEPTH), .ENTRY_W(ENTRY_W)) u_ram (
    .clk (clk),
    .we0 (we0),
    .wa0 (tail),
    .wd0 (push_data0),
    .we1 (we1),
    .wa1 (tail + PW'(1)),
    .wd1 (push_data1),
    .ra0 (head),
    .rd0 (out_data0),
    .ra1 (head + PW'(1)),
    .rd1 (out_data1)
  );

  assign count       = cnt_q;
  assign free        = free_w;
  assign out_valid0  = (cnt_q != '0);
  assign out_valid1  = (cnt_q >= CW'(2));
  assign full        = (cnt_q == CW'(DEPTH));
  assign almost_full = (free_w <= CW'(AFULL_LVL));
  assign ovf_err     = ovf_q;
  assign unf_err     = unf_q;

endmodule

// File: tb/tb_iqueue_mw.sv
// Scenario bench for iqueue_mw against a queue-based reference model.
module tb_iqueue_mw;

  localparam int DEPTH = 8;
  localparam int W     = 32;
  localparam int AF    = 2;

  logic         clk, rst_n, flush;
  logic [1:0]   push_cnt, pop_cnt;
  logic [W-1:0] push_data0, push_data1, out_data0, out_data1;
  logic         out_valid0, out_valid1, full, almost_full, ovf_err, unf_err;
  logic [3:0]   count, free;

  iqueue_mw #(.DEPTH(DEPTH), .ENTRY_W(W), .AFULL_LVL(AF)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .push_cnt    (push_cnt),
    .push_data0  (push_data0),
    .push_data1  (push_data1),
    .pop_cnt     (pop_cnt),
    .out_data0   (out_data0),
    .out_data1   (out_data1),
    .out_valid0  (out_valid0),
    .out_valid1  (out_valid1),
    .count       (count),
    .free        (free),
    .full        (full),
    .almost_full (almost_full),
    .ovf_err     (ovf_err),
    .unf_err     (unf_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: oldest entry at exp_q[0]
  logic [W-1:0] exp_q[$];
  logic         m_ovf, m_unf;
  int           checks, errors;

  task automatic model_clear_all();
    exp_q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic model_edge(input int pc, input logic [W-1:0] a, input logic [W-1:0] b,
                            input int pp, input logic fl);
    int n, room, take;
    if (fl) begin
      exp_q.delete();
      return;
    end
    n    = exp_q.size();
    room = DEPTH - n;
    if (pp == 3 || pp > n) m_unf = 1'b1;
    take = (pp < n) ? pp : n;
    for (int i = 0; i < take; i++) void'(exp_q.pop_front());
    if (pc == 3) m_unf = 1'b1;
    else if (pc > room) m_ovf = 1'b1;
    else begin
      if (pc >= 1) exp_q.push_back(a);
      if (pc == 2) exp_q.push_back(b);
    end
  endtask

  // driver tasks: drive on negedge, model updates at posedge, return at next negedge
  task automatic cycle(input int pc, input logic [W-1:0] a, input logic [W-1:0] b,
                       input int pp, input logic fl);
    push_cnt   = 2'(pc);
    push_data0 = a;
    push_data1 = b;
    pop_cnt    = 2'(pp);
    flush      = fl;
    @(posedge clk);
    model_edge(pc, a, b, pp, fl);
    @(negedge clk);
    push_cnt = 2'd0;
    pop_cnt  = 2'd0;
    flush    = 1'b0;
  endtask

  task automatic apply_reset();
    push_cnt = 2'd0; pop_cnt = 2'd0; flush = 1'b0;
    push_data0 = '0; push_data1 = '0;
    @(negedge clk);
    rst_n = 1'b0;
    model_clear_all();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    apply_reset();
    checks++; if (count !== 4'd0)   begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (free !== 4'd8)    begin errors++; $display("FAIL reset_free got=%0d exp=8", free); end
    checks++; if ({out_valid0, out_valid1, full, almost_full} !== 4'b0000)
      begin errors++; $display("FAIL reset_flags got=%b exp=0000", {out_valid0, out_valid1, full, almost_full}); end
    checks++; if ({ovf_err, unf_err} !== 2'b00)
      begin errors++; $display("FAIL reset_err got=%b exp=00", {ovf_err, unf_err}); end
  endtask

  task automatic test_push_two();
    cycle(2, 32'hAAAA_0001, 32'hBBBB_0002, 0, 1'b0);
    checks++; if (count !== 4'd2) begin errors++; $display("FAIL push2_count got=%0d exp=2", count); end
    checks++; if (out_data0 !== 32'hAAAA_0001) begin errors++; $display("FAIL push2_d0 got=%h exp=aaaa0001", out_data0); end
    checks++; if (out_data1 !== 32'hBBBB_0002) begin errors++; $display("FAIL push2_d1 got=%h exp=bbbb0002", out_data1); end
    checks++; if ({out_valid0, out_valid1} !== 2'b11) begin errors++; $display("FAIL push2_valid got=%b exp=11", {out_valid0, out_valid1}); end
    checks++; if (free !== 4'd6) begin errors++; $display("FAIL push2_free got=%0d exp=6", free); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 5; i++) cycle(1, 32'h100 + i, 32'h0, 0, 1'b0);
    checks++; if (count !== 4'd7) begin errors++; $display("FAIL fill7_count got=%0d exp=7", count); end
    cycle(2, 32'hC0C0_C0C0, 32'hD0D0_D0D0, 0, 1'b0);
    checks++; if (count !== 4'd7) begin errors++; $display("FAIL ovf_count got=%0d exp=7", count); end
    checks++; if (ovf_err !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%b exp=1", ovf_err); end
    cycle(1, 32'hC0C0_C0C0, 32'h0, 0, 1'b0);
    checks++; if ({count, full, almost_full} !== {4'd8, 2'b11})
      begin errors++; $display("FAIL fill8 got=%0d/%b%b exp=8/11", count, full, almost_full); end
    // full: push 1 with pop 2 -> pop wins, push rejected
    cycle(1, 32'hEEEE_EEEE, 32'h0, 2, 1'b0);
    checks++; if (count !== 4'd6) begin errors++; $display("FAIL fullpp_count got=%0d exp=6", count); end
    checks++; if (out_data0 !== 32'h0000_0100) begin errors++; $display("FAIL fullpp_d0 got=%h exp=00000100", out_data0); end
    checks++; if (ovf_err !== 1'b1 || unf_err !== 1'b0)
      begin errors++; $display("FAIL fullpp_err got=%b%b exp=10", ovf_err, unf_err); end
  endtask

  task automatic test_underflow();
    apply_reset();
    cycle(1, 32'h1111_1111, 32'h0, 0, 1'b0);
    cycle(0, 32'h0, 32'h0, 2, 1'b0);
    checks++; if ({count, out_valid0} !== {4'd0, 1'b0})
      begin errors++; $display("FAIL unf_count got=%0d/%b exp=0/0", count, out_valid0); end
    checks++; if (unf_err !== 1'b1) begin errors++; $display("FAIL unf_flag got=%b exp=1", unf_err); end
    // head moved one slot only: next pushes must appear at the head
    cycle(2, 32'h2222_2222, 32'h3333_3333, 0, 1'b0);
    checks++; if (out_data0 !== 32'h2222_2222 || out_data1 !== 32'h3333_3333)
      begin errors++; $display("FAIL unf_head got=%h/%h exp=22222222/33333333", out_data0, out_data1); end
    // empty + push + pop in one cycle: push accepted, pop clamped
    apply_reset();
    cycle(1, 32'h4444_4444, 32'h0, 1, 1'b0);
    checks++; if ({count, unf_err} !== {4'd1, 1'b1} || out_data0 !== 32'h4444_4444)
      begin errors++; $display("FAIL empty_pp got=%0d/%b/%h exp=1/1/44444444", count, unf_err, out_data0); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    cycle(2, 32'd0, 32'd1, 0, 1'b0);
    for (int k = 1; k < 10; k++) begin
      checks++;
      if (out_data0 !== 32'(2*k-2) || out_data1 !== 32'(2*k-1) || count !== 4'd2) begin
        errors++;
        $display("FAIL b2b_%0d got=%0d/%0d/%0d exp=%0d/%0d/2", k, out_data0, out_data1, count, 2*k-2, 2*k-1);
      end
      cycle(2, 32'(2*k), 32'(2*k+1), 2, 1'b0);
    end
    checks++;
    if (out_data0 !== 32'd18 || out_data1 !== 32'd19 || count !== 4'd2 || unf_err !== 1'b0) begin
      errors++;
      $display("FAIL b2b_last got=%0d/%0d/%0d/%b exp=18/19/2/0", out_data0, out_data1, count, unf_err);
    end
  endtask

  task automatic test_flush_and_async_reset();
    logic [1:0] errs_before;
    cycle(2, 32'h50, 32'h51, 0, 1'b0);
    cycle(1, 32'h52, 32'h0, 0, 1'b0);
    checks++; if (count !== 4'd5) begin errors++; $display("FAIL preflush_count got=%0d exp=5", count); end
    cycle(1, 32'h0, 32'h0, 3, 1'b0);
    errs_before = {m_ovf, m_unf};
    cycle(2, 32'h60, 32'h61, 1, 1'b1);
    checks++; if ({count, out_valid0, out_valid1} !== {4'd0, 2'b00})
      begin errors++; $display("FAIL flush_state got=%0d/%b%b exp=0/00", count, out_valid0, out_valid1); end
    checks++; if ({ovf_err, unf_err} !== errs_before)
      begin errors++; $display("FAIL flush_err got=%b exp=%b", {ovf_err, unf_err}, errs_before); end
    cycle(2, 32'h70, 32'h71, 0, 1'b0);
    // reset asserted between edges must act before the next edge
    @(posedge clk);
    #2 rst_n = 1'b0;
    model_clear_all();
    #1;
    checks++;
    if (count !== 4'd0 || free !== 4'd8 || {out_valid0, out_valid1, full, almost_full, ovf_err, unf_err} !== 6'b0) begin
      errors++;
      $display("FAIL async_rst got=%0d/%0d/%b exp=0/8/000000", count, free,
               {out_valid0, out_valid1, full, almost_full, ovf_err, unf_err});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_random();
    int pc, pp, n;
    logic fl;
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      pc = ($urandom_range(0, 19) == 0) ? 3 : $urandom_range(0, 2);
      pp = ($urandom_range(0, 19) == 0) ? 3 : $urandom_range(0, 2);
      fl = ($urandom_range(0, 29) == 0);
      cycle(pc, $urandom, $urandom, pp, fl);
      n = exp_q.size();
      checks++;
      if (count !== 4'(n) || free !== 4'(DEPTH - n)) begin
        errors++; $display("FAIL rnd_occ[%0d] got=%0d/%0d exp=%0d/%0d", i, count, free, n, DEPTH - n);
      end
      checks++;
      if ({out_valid0, out_valid1, full, almost_full} !== {n >= 1, n >= 2, n == DEPTH, (DEPTH - n) <= AF}) begin
        errors++; $display("FAIL rnd_flags[%0d] got=%b n=%0d", i, {out_valid0, out_valid1, full, almost_full}, n);
      end
      checks++;
      if ({ovf_err, unf_err} !== {m_ovf, m_unf}) begin
        errors++; $display("FAIL rnd_err[%0d] got=%b exp=%b", i, {ovf_err, unf_err}, {m_ovf, m_unf});
      end
      if (n >= 1) begin
        checks++;
        if (out_data0 !== exp_q[0]) begin errors++; $display("FAIL rnd_d0[%0d] got=%h exp=%h", i, out_data0, exp_q[0]); end
      end
      if (n >= 2) begin
        checks++;
        if (out_data1 !== exp_q[1]) begin errors++; $display("FAIL rnd_d1[%0d] got=%h exp=%h", i, out_data1, exp_q[1]); end
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    model_clear_all();
    test_reset();
    test_push_two();
    test_overflow();
    test_underflow();
    test_back_to_back();
    test_flush_and_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout");
    $fatal(1);
  end

endmodule

// File: doc/iqueue_mw.md
# iqueue_mw

Parametrised multi-width instruction queue between fetch/decode and issue. Accepts up to two entries per cycle and presents the two oldest to issue, which consumes 0, 1 or 2 per cycle. It flushes on redirect and reports occupancy plus sticky protocol-error flags. It generalises the single-push/single-pop instruction queue with configurable depth/width, credit-style free count and asynchronous reset.

## Interface
- `DEPTH`, 8: number of entry slots; power of 2, at least 4.
- `ENTRY_W`, 32: entry width in bits; instantiated with `$bits(lc3b_iqueue_entry)`.
- `AFULL_LVL`, 2: `almost_full` asserts when free slots are at or below this value.

- `clk`: input, 1. Rising-edge clock.
- `rst_n`: input, 1. Asynchronous active-low reset.
- `flush`: input, 1. Discard all entries; highest priority.
- `push_cnt`: input, 2. Entries offered this cycle, 0..2. The value 3 is illegal.
- `push_data0`: input, `ENTRY_W`. Older pushed entry.
- `push_data1`: input, `ENTRY_W`. Younger pushed entry, used only when `push_cnt`=2.
- `pop_cnt`: input, 2. Entries consumed this cycle, 0..2. The value 3 is illegal.
- `out_data0`: output, `ENTRY_W`. Entry at head.
- `out_data1`: output, `ENTRY_W`. Entry at head+1.
- `out_valid0`: output, 1. `count` ≥ 1.
- `out_valid1`: output, 1. `count` ≥ 2.
- `count`: output, log2(DEPTH)+1. Occupied slots.
- `free`: output, log2(DEPTH)+1. `DEPTH` − `count`.
- `full`: output, 1. `count` = `DEPTH`.
- `almost_full`: output, 1. `free` ≤ `AFULL_LVL`.
- `ovf_err`: output, 1. Sticky: a push was rejected.
- `unf_err`: output, 1. Sticky: a pop was clamped, or an illegal count value of 3 was seen.

## Operation
- Storage is a circular buffer of `DEPTH` × `ENTRY_W` with `head`/`tail` pointers of log2(DEPTH) bits. Pointers wrap modulo `DEPTH`, including +1 offsets.
- Per-cycle order on the rising edge:
  - Pop: `eff_pop` = min(`pop_cnt`, `count`). If `pop_cnt` > `count`, or `pop_cnt`=3, set `unf_err`. `head` += `eff_pop`.
  - Push: the acceptance test uses `free` from the start of the cycle. Same-cycle pops do not create space.
    - If `push_cnt` ≤ `free`, write `push_data0` at `tail` and, when `push_cnt`=2, `push_data1` at `tail`+1. Then `tail` += `push_cnt`.
    - Otherwise reject the whole push (no partial write) and set `ovf_err`. `push_cnt`=3 is always rejected and sets `unf_err`.
  - Next `count` = `count` − `eff_pop` + accepted pushes.
- `flush`: `head`, `tail` and `count` go to 0. Same-cycle push and pop are discarded. The error flags are not cleared.
- Error flags clear only on `rst_n`.
- Storage contents are not reset. `out_data*` are don't-care while the matching `out_valid*`=0.
- The outputs are combinational reads from registered state (`head`, `count`, storage). There is no input-to-output combinational path.

## Timing
- Reset (async assert, release synchronous to `clk`): `head`=`tail`=`count`=0, `free`=`DEPTH`, `out_valid0`=`out_valid1`=0, `full`=0, `almost_full`=0, `ovf_err`=`unf_err`=0.
- Push latency is 1 cycle: an entry accepted at edge N is visible on `out_data0`/`out_data1` after edge N. There is no empty-queue bypass.
- Pop takes effect at the edge. `out_data0` shows the next-oldest entry after the same edge.
- Simultaneous push and pop when full: pop succeeds and push is rejected (`ovf_err`), because the acceptance test uses start-of-cycle `free`.
- Simultaneous push and pop when empty: pop is clamped to 0 (`unf_err` if `pop_cnt` ≥ 1) and push is accepted.
- Wrap: a two-entry push at `tail`=`DEPTH`−1 writes slots `DEPTH`−1 and 0.
- Reset mid-operation: all state returns to reset values immediately, with no clock edge required.

## Structure
- `lc3b_types` holds `lc3b_iqueue_entry` and a new `IQ_DEPTH` default constant.
- Pointer and count widths are derived locally with `$clog2(DEPTH)`.
- The natural sub-module is `iq_ram2w2r`: a `DEPTH`×`ENTRY_W` register array with 2 write ports and 2 read ports. It holds no reset and no pointer logic.
- `iqueue_mw` keeps the pointers, counter, acceptance and clamp logic, and the error flags.

## Test plan
- Reset, then push_cnt=2 with data A,B at edge 1 → after edge 1: count=2, out_data0=A, out_data1=B, both valids=1, free=6.
- DEPTH=8, fill to count=7, then push_cnt=2 with C,D → push rejected, count stays 7, ovf_err=1. Then push_cnt=1 with C → count=8, full=1, almost_full=1.
- count=8, push_cnt=1 with pop_cnt=2 in the same cycle → count=6, ovf_err=1, out_data0 = the 3rd-oldest entry.
- count=1, pop_cnt=2 → count=0, out_valid0=0, unf_err=1, head advanced by 1 only.
- Repeated push_cnt=2 with pop_cnt=2 for 10 cycles using sequential data 0..19 → out_data0/out_data1 follow the order 0,1 / 2,3 / … across the wrap, count held at 2.
- count=5, flush together with push_cnt=2 and pop_cnt=1 → count=0, valids=0, errors unchanged. Then drop rst_n mid-cycle → all outputs at reset values before the next edge.
